lsb_second_bit_set_finder: RTL and testbench

LSB_SECOND_BIT_SET_FINDER -- requirements
Module: lsb_second_bit_set_finder

---
 rtl/lsb_sb_finder_pkg.sv | 22 ++
 rtl/lsb_first_bit_set_finder.sv | 19 +
 rtl/lsb_second_bit_set_finder.sv | 83 ++++++++
 tb/tb_lsb_second_bit_set_finder.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/lsb_sb_finder_pkg.sv
// Shared constants and helpers for the second-lowest-set-bit finder.
package lsb_sb_finder_pkg;

    localparam int DEFAULT_WIDTH = 12;
    localparam int MAX_WIDTH     = 64;
    localparam int MAX_IDX_W     = 6;

    // OR-encode a one-hot vector into its binary bit position; all-zero maps to 0.
    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_WIDTH-1:0] onehot);
        logic [MAX_IDX_W-1:0] idx;
        idx = {MAX_IDX_W{1'b0}};
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (onehot[i]) begin
                idx = idx | MAX_IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/lsb_first_bit_set_finder.sv
// Combinational isolation of the lowest set bit of a vector as a one-hot value.
module lsb_first_bit_set_finder
    import lsb_sb_finder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] vec,
    output logic [WIDTH-1:0] first
);

    logic [WIDTH-1:0] neg_s;

    // Two's-complement negate; ANDing with the original keeps only the lowest 1.
    always_comb begin
        neg_s = ~vec + {{(WIDTH-1){1'b0}}, 1'b1};
        first = vec & neg_s;
    end

endmodule

// File: rtl/lsb_second_bit_set_finder.sv
// Registered one-hot (and optional binary index) of the second-lowest set bit.
// Define LSB_SB_FINDER_IDX_EN to add the second_idx_o port and its encoder.
module lsb_second_bit_set_finder
    import lsb_sb_finder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] vec_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] second_bit_o,
    output logic             found_o
`ifdef LSB_SB_FINDER_IDX_EN
    ,
    output logic [IDX_W-1:0] second_idx_o
`endif
);

    logic [WIDTH-1:0] first_s;
    logic [WIDTH-1:0] rest_s;
    logic [WIDTH-1:0] second_s;
    logic             found_s;

    lsb_first_bit_set_finder #(.WIDTH(WIDTH)) u_first (
        .vec   (vec_i),
        .first (first_s)
    );

    lsb_first_bit_set_finder #(.WIDTH(WIDTH)) u_second (
        .vec   (rest_s),
        .first (second_s)
    );

    // Drop the lowest set bit so the second finder sees only what lies above it.
    always_comb begin
        rest_s  = vec_i & ~first_s;
        found_s = |second_s;
    end

`ifdef LSB_SB_FINDER_IDX_EN
    logic [MAX_WIDTH-1:0] second_wide_s;
    logic [MAX_IDX_W-1:0] idx_wide_s;

    // Widen to the helper's fixed width before encoding.
    always_comb begin
        second_wide_s              = {MAX_WIDTH{1'b0}};
        second_wide_s[WIDTH-1:0]   = second_s;
        idx_wide_s                 = onehot_to_idx(second_wide_s);
    end

    // Index register follows the same load/hold rule as the one-hot output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            second_idx_o <= {IDX_W{1'b0}};
        end else if (valid_i) begin
            second_idx_o <= idx_wide_s[IDX_W-1:0];
        end else begin
            second_idx_o <= second_idx_o;
        end
    end
`endif

    // Output registers: load on valid, otherwise hold data and drop valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_o      <= 1'b0;
            second_bit_o <= {WIDTH{1'b0}};
            found_o      <= 1'b0;
        end else if (valid_i) begin
            valid_o      <= 1'b1;
            second_bit_o <= second_s;
            found_o      <= found_s;
        end else begin
            valid_o      <= 1'b0;
            second_bit_o <= second_bit_o;
            found_o      <= found_o;
        end
    end

endmodule

// File: tb/tb_lsb_second_bit_set_finder.sv
// Directed and exhaustive checks of lsb_second_bit_set_finder at WIDTH=12.
module tb_lsb_second_bit_set_finder;

    localparam int WIDTH = 12;
    localparam int IDX_W = $clog2(WIDTH);

    logic             clk;
    logic             reset;
    logic             valid_i;
    logic [WIDTH-1:0] vec_i;
    logic             valid_o;
    logic [WIDTH-1:0] second_bit_o;
    logic             found_o;
`ifdef LSB_SB_FINDER_IDX_EN
    logic [IDX_W-1:0] second_idx_o;
`endif

    int n_cmp;
    int n_err;

    lsb_second_bit_set_finder #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_i      (valid_i),
        .vec_i        (vec_i),
        .valid_o      (valid_o),
        .second_bit_o (second_bit_o),
        .found_o      (found_o)
`ifdef LSB_SB_FINDER_IDX_EN
        ,
        .second_idx_o (second_idx_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: walk up from bit 0 and stop at the second 1 encountered.
    function automatic logic [WIDTH-1:0] ref_second(input logic [WIDTH-1:0] v);
        int cnt;
        logic [WIDTH-1:0] r;
        cnt = 0;
        r   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i] && cnt < 2) begin
                cnt++;
                if (cnt == 2) r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic int ref_idx(input logic [WIDTH-1:0] v);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i] && cnt < 2) begin
                cnt++;
                if (cnt == 2) pos = i;
            end
        end
        return pos;
    endfunction

    task automatic check_outputs(input string tag, input logic exp_valid,
                                 input logic [WIDTH-1:0] exp_bit, input logic exp_found,
                                 input int exp_idx);
        check_eq({tag, ".valid"}, 64'(valid_o), 64'(exp_valid));
        check_eq({tag, ".bit"},   64'(second_bit_o), 64'(exp_bit));
        check_eq({tag, ".found"}, 64'(found_o), 64'(exp_found));
`ifdef LSB_SB_FINDER_IDX_EN
        check_eq({tag, ".idx"},   64'(second_idx_o), 64'(exp_idx));
`endif
    endtask

    // Present one vector on the negedge and check the result just after the posedge.
    task automatic drive_check(input string tag, input logic [WIDTH-1:0] v,
                               input logic [WIDTH-1:0] exp_bit, input logic exp_found,
                               input int exp_idx);
        @(negedge clk);
        valid_i = 1'b1;
        vec_i   = v;
        @(posedge clk);
        #1;
        check_outputs(tag, 1'b1, exp_bit, exp_found, exp_idx);
    endtask

    task automatic idle_check(input string tag, input logic [WIDTH-1:0] exp_bit,
                              input logic exp_found, input int exp_idx);
        @(negedge clk);
        valid_i = 1'b0;
        vec_i   = 12'hFFF;
        @(posedge clk);
        #1;
        check_outputs(tag, 1'b0, exp_bit, exp_found, exp_idx);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        reset   = 1'b1;
        valid_i = 1'b0;
        vec_i   = 12'h000;
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset", 1'b0, 12'h000, 1'b0, 0);
        @(negedge clk);
        reset = 1'b0;

        // Zero or one set bit
        drive_check("z000", 12'h000, 12'h000, 1'b0, 0);
        drive_check("z001", 12'h001, 12'h000, 1'b0, 0);
        drive_check("z010", 12'h010, 12'h000, 1'b0, 0);
        drive_check("z100", 12'h100, 12'h000, 1'b0, 0);
        drive_check("z800", 12'h800, 12'h000, 1'b0, 0);

        // Two or more set bits, including the MSB boundary
        drive_check("v003", 12'h003, 12'h002, 1'b1, 1);
        drive_check("vFF0", 12'hFF0, 12'h020, 1'b1, 5);
        drive_check("vF00", 12'hF00, 12'h200, 1'b1, 9);
        drive_check("vC00", 12'hC00, 12'h800, 1'b1, 11);
        drive_check("vFFF", 12'hFFF, 12'h002, 1'b1, 1);
        drive_check("v801", 12'h801, 12'h800, 1'b1, 11);

        // Hold of a nonzero result once valid drops
        idle_check("hold801", 12'h800, 1'b1, 11);
        idle_check("hold801b", 12'h800, 1'b1, 11);

        // Back-to-back stream then idle
        drive_check("b2b0", 12'h003, 12'h002, 1'b1, 1);
        drive_check("b2b1", 12'hC00, 12'h800, 1'b1, 11);
        drive_check("b2b2", 12'h000, 12'h000, 1'b0, 0);
        idle_check("b2bidle", 12'h000, 1'b0, 0);

        // Asynchronous reset between edges while a result is valid
        drive_check("prersv", 12'hC00, 12'h800, 1'b1, 11);
        @(negedge clk);
        valid_i = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        check_outputs("asyncrst", 1'b0, 12'h000, 1'b0, 0);
        @(negedge clk);
        reset = 1'b0;
        drive_check("postrst", 12'h003, 12'h002, 1'b1, 1);

        // Exhaustive sweep against the reference model
        for (int k = 0; k < (1 << WIDTH); k++) begin
            logic [WIDTH-1:0] v;
            logic [WIDTH-1:0] e;
            v = WIDTH'(k);
            e = ref_second(v);
            drive_check("sweep", v, e, |e, ref_idx(v));
        end
        idle_check("final", ref_second(12'hFFF), 1'b1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
